mem_seq: RTL and testbench

//  Byte-serial memory access sequencer and arbiter. Shares one 8-bit memory port between

---
 rtl/mem_seq_pkg.sv | 34 +++
 rtl/mem_seq_load_ext.sv | 24 ++
 rtl/mem_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the byte-serial memory sequencer: access size codes,
// FSM state encoding, round-robin owner encoding and a size-to-byte-count helper.
package mem_seq_pkg;

  // Data access size codes carried on i_d_size.
  localparam logic [1:0] SzNone = 2'd0;
  localparam logic [1:0] SzB    = 2'd1;
  localparam logic [1:0] SzH    = 2'd2;
  localparam logic [1:0] SzW    = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StResp = 2'd2
  } state_e;

  // Which requester was granted most recently.
  typedef enum logic {
    RrFetch = 1'b0,
    RrData  = 1'b1
  } rr_e;

  // Number of byte cycles for an access. Word and fetch accesses use SzW.
  function automatic logic [2:0] size_nbytes(logic [1:0] size);
    logic [2:0] n;
    case (size)
      SzB:     n = 3'd1;
      SzH:     n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_seq_load_ext.sv
// Load data extension, purely combinational.
//   raw_i  : little-endian assembled load bytes (unused upper bytes are zero)
//   size_i : access size code
//   sign_i : 1 = sign-extend, 0 = zero-extend
//   ext_o  : extended 32-bit word (words pass through unchanged)
module mem_seq_load_ext
  import mem_seq_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SzB:     ext_o = {{24{sign_i & raw_i[7]}}, raw_i[7:0]};
      SzH:     ext_o = {{16{sign_i & raw_i[15]}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_seq.sv
// Byte-serial memory access sequencer and arbiter. Shares one 8-bit memory port
// between instruction fetch (word only) and the load/store data path. Each access
// is split into 1/2/4 little-endian byte cycles; load data is reassembled and extended.
// Simultaneous requests are granted round-robin; stuck byte cycles are aborted after
// TIMEOUT wait cycles (0 disables the watchdog).
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_if_req/i_if_addr             fetch request (level), byte address
//   o_if_ack/o_if_data             one-cycle completion pulse, fetched word
//   i_d_req/we/size/sign/addr/wdata  data request (level) and its attributes
//   o_d_ack/o_d_rdata              one-cycle completion pulse, extended load data
//   o_err                          pulses with an ack when that access timed out
//   o_mem_req/we/addr/wdata        byte memory port request
//   i_mem_ack/i_mem_rdata          byte done, read byte
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_ack,
  output logic [31:0]   o_if_data,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [1:0]    i_d_size,
  input  logic          i_d_sign,
  input  logic [AW-1:0] i_d_addr,
  input  logic [31:0]   i_d_wdata,
  output logic          o_d_ack,
  output logic [31:0]   o_d_rdata,
  output logic          o_err,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [7:0]    o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [7:0]    i_mem_rdata
);

  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  rr_e              rr_last_q, rr_last_d;
  logic             is_data_q, is_data_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [AW-1:0]    base_q, base_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       k_q, k_d;
  logic [2:0]       nbytes_q, nbytes_d;
  logic [31:0]      raw_q, raw_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             if_ack_q, if_ack_d;
  logic [31:0]      if_data_q, if_data_d;
  logic             d_ack_q, d_ack_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             err_q, err_d;

  logic [31:0]      raw_nxt;
  logic [31:0]      ext_data;
  logic             grant_data;
  logic             finish;
  logic             timed_out;

  // Raw load word including the byte arriving this cycle, so the final byte can be
  // extended and presented in the same edge that enters RESP.
  always_comb begin
    raw_nxt = raw_q;
    if (state_q == StXfer && i_mem_ack && !we_q) begin
      raw_nxt[{k_q, 3'b000} +: 8] = i_mem_rdata;
    end
  end

  mem_seq_load_ext u_load_ext (
    .raw_i  (raw_nxt),
    .size_i (size_q),
    .sign_i (sign_q),
    .ext_o  (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    is_data_d   = is_data_q;
    we_d        = we_q;
    size_d      = size_q;
    sign_d      = sign_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    nbytes_d    = nbytes_q;
    raw_d       = raw_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_data_d   = '0;
    d_ack_d     = 1'b0;
    d_rdata_d   = '0;
    err_d       = 1'b0;
    grant_data  = 1'b0;
    finish      = 1'b0;
    timed_out   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie the data side wins unless it was granted last.
        grant_data = i_d_req && (!i_if_req || rr_last_q == RrFetch);
        if (i_d_req || i_if_req) begin
          is_data_d = grant_data;
          rr_last_d = grant_data ? RrData : RrFetch;
          base_d    = grant_data ? i_d_addr : i_if_addr;
          we_d      = grant_data & i_d_we;
          size_d    = grant_data ? i_d_size : SzW;
          sign_d    = grant_data & i_d_sign;
          wdata_d   = grant_data ? i_d_wdata : '0;
          nbytes_d  = size_nbytes(size_d);
          k_d       = '0;
          raw_d     = '0;
          wait_d    = '0;
          if (grant_data && i_d_size == SzNone) begin
            // Nothing to transfer: acknowledge directly with zero data.
            state_d = StResp;
            d_ack_d = 1'b1;
          end else begin
            state_d     = StXfer;
            mem_req_d   = 1'b1;
            mem_we_d    = we_d;
            mem_addr_d  = base_d;
            mem_wdata_d = wdata_d[7:0];
          end
        end
      end

      StXfer: begin
        if (i_mem_ack) begin
          raw_d  = raw_nxt;
          wait_d = '0;
          if ({1'b0, k_q} + 3'd1 == nbytes_q) begin
            finish = 1'b1;
          end else begin
            k_d         = k_q + 2'd1;
            mem_addr_d  = base_q + AW'(k_d);
            mem_wdata_d = wdata_q[{k_d, 3'b000} +: 8];
          end
        end else if (TIMEOUT != 0) begin
          if (wait_q == WaitW'(TIMEOUT - 1)) begin
            finish    = 1'b1;
            timed_out = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end

        if (finish) begin
          state_d     = StResp;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          err_d       = timed_out;
          if (is_data_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = we_q ? '0 : ext_data;
          end else begin
            if_ack_d  = 1'b1;
            if_data_d = raw_nxt;
          end
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      rr_last_q   <= RrFetch;
      is_data_q   <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= SzNone;
      sign_q      <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      k_q         <= '0;
      nbytes_q    <= '0;
      raw_q       <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_data_q   <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      is_data_q   <= is_data_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      nbytes_q    <= nbytes_d;
      raw_q       <= raw_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_data_q   <= if_data_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_ack    = if_ack_q;
  assign o_if_data   = if_data_q;
  assign o_d_ack     = d_ack_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mem_seq.sv
// Directed self-checking bench for mem_seq with a byte memory model that supports
// programmable wait states and a "never acknowledge" mode.
module tb_mem_seq;
  localparam int unsigned AW = 32;
  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_B    = 2'd1;
  localparam logic [1:0] SZ_H    = 2'd2;
  localparam logic [1:0] SZ_W    = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_ack;
  logic [31:0]   o_if_data;
  logic          i_d_req;
  logic          i_d_we;
  logic [1:0]    i_d_size;
  logic          i_d_sign;
  logic [AW-1:0] i_d_addr;
  logic [31:0]   i_d_wdata;
  logic          o_d_ack;
  logic [31:0]   o_d_rdata;
  logic          o_err;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_seq #(
    .AW      (AW),
    .TIMEOUT (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_ack    (o_if_ack),
    .o_if_data   (o_if_data),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_size    (i_d_size),
    .i_d_sign    (i_d_sign),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_ack     (o_d_ack),
    .o_d_rdata   (o_d_rdata),
    .o_err       (o_err),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata)
  );

  // Byte memory model: acks after wait_states stall cycles, logs every completed byte.
  logic [7:0]    mem [256];
  int            wait_states = 0;
  bit            no_ack = 1'b0;
  int            wcnt = 0;
  logic [AW-1:0] log_addr[$];
  logic          log_we[$];
  logic [7:0]    log_byte[$];

  always_comb mem_ack = o_mem_req && !no_ack && (wcnt >= wait_states);
  assign mem_rdata = mem[o_mem_addr[7:0]];

  always @(posedge clk) begin
    if (!o_mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (o_mem_req && mem_ack) begin
      log_addr.push_back(o_mem_addr);
      log_we.push_back(o_mem_we);
      log_byte.push_back(o_mem_we ? o_mem_wdata : mem_rdata);
    end
  end

  int          lat;
  bit          got_if, got_d, got_err;
  logic [31:0] got_ifd, got_dd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_byte.delete();
  endtask

  // Waits for one ack pulse (bounded); lat counts cycles after the request cycle.
  task automatic wait_ack(input string tag);
    lat = 0; got_if = 0; got_d = 0; got_err = 0; got_ifd = '0; got_dd = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (o_if_ack || o_d_ack) begin
        lat = n; got_if = o_if_ack; got_d = o_d_ack; got_err = o_err;
        got_ifd = o_if_data; got_dd = o_d_rdata;
        if (o_if_ack) i_if_req = 1'b0;
        if (o_d_ack) i_d_req = 1'b0;
        break;
      end
    end
    check({tag, "_ack_seen"}, 64'(lat != 0), 64'd1);
  endtask

  task automatic start_d(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    clear_log();
    i_d_req = 1'b1; i_d_we = we; i_d_size = size; i_d_sign = sign;
    i_d_addr = addr; i_d_wdata = wdata;
  endtask

  task automatic start_if(input logic [31:0] addr);
    @(posedge clk); #1;
    clear_log();
    i_if_req = 1'b1; i_if_addr = addr;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] seq;
    int          nacks;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'hEF; mem[1] = 8'hBE; mem[2] = 8'hAD; mem[3] = 8'hDE;
    mem[6] = 8'h11; mem[7] = 8'h80; mem[255] = 8'h7F;

    rst_n = 1'b0;
    i_if_req = 0; i_if_addr = '0; i_d_req = 0; i_d_we = 0; i_d_size = '0;
    i_d_sign = 0; i_d_addr = '0; i_d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 64'(o_mem_req), 64'd0);
    check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check("rst_if_ack", 64'(o_if_ack), 64'd0);
    check("rst_d_ack", 64'(o_d_ack), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    #2 rst_n = 1'b1;

    // Word fetch, zero-wait memory.
    start_if(32'h100);
    wait_ack("fetch");
    check("fetch_lat", 64'(lat), 64'd5);
    check("fetch_is_if", 64'(got_if), 64'd1);
    check("fetch_data", 64'(got_ifd), 64'hDEADBEEF);
    check("fetch_err", 64'(got_err), 64'd0);
    check("fetch_nbytes", 64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("fetch_addr%0d", i), 64'(log_addr[i]), 64'h100 + 64'(i));

    // Both requesters held: data wins first (last grant was fetch), then alternate.
    @(posedge clk); #1;
    i_d_req = 1; i_d_we = 0; i_d_size = SZ_B; i_d_sign = 1; i_d_addr = 32'h7;
    i_if_req = 1; i_if_addr = 32'h100;
    seq = '0; nacks = 0;
    for (int n = 0; n < 100 && nacks < 4; n++) begin
      @(posedge clk); #1;
      if (o_d_ack) begin
        seq = {seq[23:0], 8'h44}; nacks++;
        if (nacks == 1) check("arb_d_data", 64'(o_d_rdata), 64'hFFFFFF80);
        if (nacks == 3) i_d_req = 0;
      end
      if (o_if_ack) begin
        seq = {seq[23:0], 8'h46}; nacks++;
        if (nacks == 2) check("arb_f_data", 64'(o_if_data), 64'hDEADBEEF);
        if (nacks == 4) i_if_req = 0;
      end
    end
    check("arb_order_DFDF", 64'(seq), 64'h44464446);
    i_d_req = 0; i_if_req = 0;

    // Byte loads, signed and unsigned.
    start_d(0, SZ_B, 1, 32'h7, '0);
    wait_ack("ldb_s");
    check("ldb_s_lat", 64'(lat), 64'd2);
    check("ldb_s_data", 64'(got_dd), 64'hFFFFFF80);
    start_d(0, SZ_B, 0, 32'h7, '0);
    wait_ack("ldb_u");
    check("ldb_u_data", 64'(got_dd), 64'h00000080);

    // Signed halfword, misaligned.
    start_d(0, SZ_H, 1, 32'h6, '0);
    wait_ack("ldh_s");
    check("ldh_s_lat", 64'(lat), 64'd3);
    check("ldh_s_data", 64'(got_dd), 64'hFFFF8011);

    // Halfword store with two wait states per byte.
    wait_states = 2;
    start_d(1, SZ_H, 0, 32'h3, 32'hCAFE1234);
    wait_ack("sth");
    check("sth_lat", 64'(lat), 64'd7);
    check("sth_is_d", 64'(got_d), 64'd1);
    check("sth_rdata", 64'(got_dd), 64'd0);
    check("sth_nbytes", 64'(log_addr.size()), 64'd2);
    check("sth_b0", {31'd0, log_we[0], log_addr[0][23:0], log_byte[0]}, {31'd0, 1'b1, 24'h3, 8'h34});
    check("sth_b1", {31'd0, log_we[1], log_addr[1][23:0], log_byte[1]}, {31'd0, 1'b1, 24'h4, 8'h12});

    // Word load with one wait state per byte.
    wait_states = 1;
    start_d(0, SZ_W, 1, 32'h0, '0);
    wait_ack("ldw");
    check("ldw_lat", 64'(lat), 64'd9);
    check("ldw_data", 64'(got_dd), 64'hDEADBEEF);
    wait_states = 0;

    // Halfword crossing the top of the address space wraps to 0.
    start_d(0, SZ_H, 0, 32'hFFFF_FFFF, '0);
    wait_ack("wrap");
    check("wrap_data", 64'(got_dd), 64'h0000EF7F);
    check("wrap_addr0", 64'(log_addr[0]), 64'hFFFF_FFFF);
    check("wrap_addr1", 64'(log_addr[1]), 64'h0);

    // Watchdog: memory never acknowledges.
    no_ack = 1;
    start_d(0, SZ_B, 0, 32'h10, '0);
    wait_ack("tmo");
    check("tmo_lat", 64'(lat), 64'd5);
    check("tmo_err", 64'(got_err), 64'd1);
    check("tmo_is_d", 64'(got_d), 64'd1);
    check("tmo_rdata", 64'(got_dd), 64'd0);
    check("tmo_resp_memreq", 64'(o_mem_req), 64'd0);
    no_ack = 0;

    // Size-none request: no bus cycle, ack next cycle.
    start_d(0, SZ_NONE, 1, 32'h7, '0);
    wait_ack("none");
    check("none_lat", 64'(lat), 64'd1);
    check("none_rdata", 64'(got_dd), 64'd0);
    check("none_nbytes", 64'(log_addr.size()), 64'd0);
    check("none_err", 64'(got_err), 64'd0);

    // Reset in the middle of a word fetch.
    start_if(32'h200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_memreq", 64'(o_mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_memreq", 64'(o_mem_req), 64'd0);
    check("mid_rst_addr", 64'(o_mem_addr), 64'd0);
    i_if_req = 0;
    nacks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (o_if_ack || o_d_ack) nacks++;
    end
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_if_ack || o_d_ack) nacks++;
    end
    check("mid_no_ack", 64'(nacks), 64'd0);
    start_if(32'h200);
    wait_ack("refetch");
    check("refetch_lat", 64'(lat), 64'd5);
    check("refetch_data", 64'(got_ifd), 64'hDEADBEEF);
    check("refetch_addr0", 64'(log_addr[0]), 64'h200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
